decoder_rr_arbiter: RTL and testbench

Round-robin arbiter granting one of eight requesters exclusive use of a shared resource. The winning 3-bit index drives an internal 3-to-8 one-hot decoder, and the decoder output is the registered grant vector. The block sits between the requesting agents and the resource select lines, sequencing ownership so exactly one select line is ever active.

---
 rtl/arb_pkg.sv | 14 +
 rtl/onehot_dec8.sv | 15 +
 rtl/decoder_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// Holds the state enum, requester count, index width, default hold limit.
package arb_pkg;

  localparam int NUM_REQ      = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_dec8.sv
// Combinational 3-to-8 one-hot decoder.
// Ports: idx (binary index in), onehot (exactly one bit set out).
module onehot_dec8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant vector.
// Ports: clk, rst (sync, active-high), req[7:0], gnt[7:0], gnt_idx[2:0],
// gnt_valid, timeout. Define ARB_TIMEOUT_EN to enable forced rotation
// after MAX_HOLD grant cycles; without it timeout is tied to 0.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..255");
  end

  // Rotate so the slot after last sits at bit 0, take the lowest set
  // bit, then rotate the index back.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0]     start;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     ffs;
    start = last + 3'd1;
    dbl   = {r, r} >> start;
    rot   = dbl[NUM_REQ-1:0];
    ffs   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) ffs = i[IDX_W-1:0];
    end
    return ffs + start;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;

  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;

  assign win_idx = rr_pick(req, last_q);

  onehot_dec8 u_dec (
    .idx    (win_idx),
    .onehot (win_oh)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;
  logic       tmo_q, tmo_d;
  logic       others;

  assign others = |(req & ~gnt_q);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = win_idx;
          gnt_d   = win_oh;
          vld_d   = 1'b1;
          last_d  = win_idx;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          gnt_d   = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_TOP && others) begin
          // last_idx stays on the revoked owner
          gnt_d   = '0;
          vld_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else if (hold_q != HOLD_TOP) begin
          hold_d  = hold_q + 8'd1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      idx_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter.
// Vector table, directed sequences, random run against a behavioural model.
module tb_decoder_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  // model state
  int m_owner;
  int m_last;
  int m_hold;
  bit m_tmo;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       v;
    logic [2:0] idx;
    logic       t;
  } vec_t;

  vec_t tab [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances by the spec rules at each rising edge.
  task automatic model_step(input logic [7:0] r, input logic rs);
    m_tmo = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_last  = 7;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        for (int k = 1; k <= 8; k++) begin
          int c;
          c = (m_last + k) % 8;
          if (r[c] && m_owner < 0) m_owner = c;
        end
        m_last = m_owner;
        m_hold = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MH - 1 && (r & ~(8'd1 << m_owner)) != 0) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
`endif
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] g,
                         input logic v, input logic t);
    chk({nm, ".gnt"}, 32'(gnt), 32'(g));
    chk({nm, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({nm, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] eg;
    req = 8'h00;
    rst = 1'b1;
    m_owner = -1;
    m_last = 7;
    m_hold = 0;
    m_tmo = 0;

    tab[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[1]  = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
    tab[2]  = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
    tab[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[5]  = '{1'b0, 8'h40, 8'h40, 1'b1, 3'd6, 1'b0};
    tab[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[7]  = '{1'b0, 8'h03, 8'h01, 1'b1, 3'd0, 1'b0};
    tab[8]  = '{1'b0, 8'h03, 8'h01, 1'b1, 3'd0, 1'b0};
    tab[9]  = '{1'b0, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[10] = '{1'b0, 8'h03, 8'h02, 1'b1, 3'd1, 1'b0};
    tab[11] = '{1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0};
    tab[12] = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(tab[i].req, tab[i].rst);
      chk_out($sformatf("tab%0d", i), tab[i].gnt, tab[i].v, tab[i].t);
      if (tab[i].v || tab[i].rst)
        chk($sformatf("tab%0d.idx", i), 32'(gnt_idx), 32'(tab[i].idx));
    end

    // rotation with all requesting
    step(8'h00, 1'b1);
    step(8'hFF, 1'b0);
    chk_out("rot.first", 8'h01, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      r = 8'hFF & ~(8'd1 << k);
      step(r, 1'b0);
      chk_out($sformatf("rot.gap%0d", k), 8'h00, 1'b0, 1'b0);
      step(8'hFF, 1'b0);
      eg = 8'd1 << ((k + 1) % 8);
      chk_out($sformatf("rot.own%0d", (k + 1) % 8), eg, 1'b1, 1'b0);
      chk($sformatf("rot.idx%0d", (k + 1) % 8), 32'(gnt_idx),
          32'((k + 1) % 8));
    end

    // mid-grant reset
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    chk_out("mrst.own5", 8'h20, 1'b1, 1'b0);
    step(8'hFF, 1'b1);
    chk_out("mrst.rst", 8'h00, 1'b0, 1'b0);
    chk("mrst.idx", 32'(gnt_idx), 32'd0);
    step(8'hFF, 1'b0);
    chk_out("mrst.next", 8'h01, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    step(8'h00, 1'b1);
    step(8'h02, 1'b0);
    chk_out("to.g0", 8'h02, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step(8'h0A, 1'b0);
      chk_out($sformatf("to.g%0d", k), 8'h02, 1'b1, 1'b0);
    end
    step(8'h0A, 1'b0);
    chk_out("to.revoke", 8'h00, 1'b0, 1'b1);
    step(8'h0A, 1'b0);
    chk_out("to.next", 8'h08, 1'b1, 1'b0);
    step(8'h00, 1'b0);
    chk_out("to.rel", 8'h00, 1'b0, 1'b0);
    step(8'h02, 1'b0);
    chk_out("to.solo0", 8'h02, 1'b1, 1'b0);
    for (int k = 1; k < 12; k++) begin
      step(8'h02, 1'b0);
      chk_out($sformatf("to.solo%0d", k), 8'h02, 1'b1, 1'b0);
    end
`endif

    // random run against the model
    step(8'h00, 1'b1);
    r = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      logic rs;
      if ($urandom_range(3) == 0) r = 8'($urandom);
      if ($urandom_range(7) == 0) r = r & 8'($urandom);
      rs = ($urandom_range(199) == 0);
      step(r, rs);
      eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
      tests++;
      if (gnt !== eg || gnt_valid !== (m_owner >= 0) || timeout !== m_tmo
          || (m_owner >= 0 && gnt_idx !== 3'(m_owner))) begin
        fails++;
        $display("FAIL rnd%0d: got gnt=%h v=%b idx=%0d t=%b want gnt=%h t=%b",
                 n, gnt, gnt_valid, gnt_idx, timeout, eg, m_tmo);
      end
      tests++;
      if ($countones(gnt) > 1 ||
          (gnt_valid && gnt !== (8'd1 << gnt_idx)) ||
          (!gnt_valid && gnt !== 8'h00)) begin
        fails++;
        $display("FAIL onehot%0d: got gnt=%h v=%b idx=%0d",
                 n, gnt, gnt_valid, gnt_idx);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
